pwm_generator: RTL

Per-transducer PWM output stage, run on the 200 MHz PWM clock. It sits directly downstream of the step-limited duty/phase smoother (`silent`) and takes that stage's `DUTY_S`, `PHASE_S` and `OUT_VALID` outputs. For each channel it keeps a free-running period counter and converts duty/phase into rise/fall edges. New settings are double-buffered so a change only takes effect at a period boundary. The output is one glitch-free, phase-centred pulse per ultrasound period for every channel.

---
 rtl/pwm_generator.sv | 78 +++++++
 1 files changed

// File: rtl/pwm_generator.sv
// pwm_generator: double-buffered, phase-centred PWM output stage, one pulse per period per channel
module pwm_generator #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 1
) (
  input  logic             CLK_PWM,
  input  logic             RST_N,
  input  logic             SYNC,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] CYCLE        [0:DEPTH-1],
  input  logic [WIDTH-1:0] DUTY         [0:DEPTH-1],
  input  logic [WIDTH-1:0] PHASE        [0:DEPTH-1],
  output logic             PWM_OUT      [0:DEPTH-1],
  output logic             PERIOD_START [0:DEPTH-1]
);
  for (genvar c = 0; c < DEPTH; c++) begin : g_ch
    logic [WIDTH-1:0]        cyc_p_q, rise_p_q, fall_p_q;
    logic [WIDTH-1:0]        cyc_a_q, rise_a_q, fall_a_q;
    logic                    full_p_q, full_a_q;
    logic [WIDTH-1:0]        t_q, t_d;
    logic                    pwm_q, pwm_d, ps_q;
    logic                    swap;
    logic [WIDTH-1:0]        ph, h, rise_d, fall_d;
    logic signed [WIDTH:0]   rs;
    logic [WIDTH:0]          fs;
    // rise/fall edges from centre and duty; the odd extra clock of DUTY lands after the centre
    always_comb begin
      ph     = PHASE[c] < CYCLE[c] ? PHASE[c] : PHASE[c] - CYCLE[c];
      h      = DUTY[c] >> 1;
      rs     = $signed({1'b0, ph}) - $signed({1'b0, h});
      rise_d = rs[WIDTH] ? rs[WIDTH-1:0] + CYCLE[c] : rs[WIDTH-1:0];
      fs     = {1'b0, ph} + {1'b0, DUTY[c] - h};
      fall_d = fs >= {1'b0, CYCLE[c]} ? fs[WIDTH-1:0] - CYCLE[c] : fs[WIDTH-1:0];
    end
    // counter wrap/realign and the next output level from the active bank
    always_comb begin
      swap  = SYNC || cyc_a_q < WIDTH'(2) || t_q >= cyc_a_q - WIDTH'(1);
      t_d   = swap ? '0 : t_q + WIDTH'(1);
      pwm_d = full_a_q             ? 1'b1 :
              rise_a_q < fall_a_q  ? (t_q >= rise_a_q && t_q < fall_a_q) :
              rise_a_q > fall_a_q  ? (t_q >= rise_a_q || t_q < fall_a_q) : 1'b0;
    end
    // pending bank captures each strobe; active bank only changes at a period boundary or SYNC
    always_ff @(posedge CLK_PWM or negedge RST_N) begin
      if (!RST_N) begin
        cyc_p_q  <= '0;
        rise_p_q <= '0;
        fall_p_q <= '0;
        full_p_q <= 1'b0;
        cyc_a_q  <= '0;
        rise_a_q <= '0;
        fall_a_q <= '0;
        full_a_q <= 1'b0;
        t_q      <= '0;
        pwm_q    <= 1'b0;
        ps_q     <= 1'b0;
      end else begin
        if (IN_VALID) begin
          cyc_p_q  <= CYCLE[c];
          rise_p_q <= rise_d;
          fall_p_q <= fall_d;
          full_p_q <= DUTY[c] >= CYCLE[c];
        end
        if (swap) begin
          cyc_a_q  <= cyc_p_q;
          rise_a_q <= rise_p_q;
          fall_a_q <= fall_p_q;
          full_a_q <= full_p_q;
        end
        t_q   <= t_d;
        pwm_q <= pwm_d;
        ps_q  <= t_q == '0;
      end
    end
    assign PWM_OUT[c]      = pwm_q;
    assign PERIOD_START[c] = ps_q;
  end
endmodule
